alignment_cigar_encoder: RTL and testbench

- Downstream of the banded Smith-Waterman accelerator. Consumes its packed aligned R/Q vectors when the accelerator raises its ready flag.
- Walks the alignment one column per cycle, accumulates a linear-gap alignment score and run-length encodes the column ops into a CIGAR stream.
- The CIGAR stream goes out on a single-entry valid/ready port towards the host/readout logic.

---
 rtl/alignment_cigar_encoder.sv | 211 +++++++++++++++++++++
 tb/tb_alignment_cigar_encoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alignment_cigar_encoder.sv
// Walks a captured R/Q alignment one column per cycle, scores it with linear gaps and
// run-length encodes the column ops into a single-entry valid/ready CIGAR stream.
module alignment_cigar_encoder #(
    parameter int unsigned L           = 8,
    parameter int signed   MATCH_SC    = 2,
    parameter int signed   MISMATCH_SC = -1,
    parameter int signed   GAP_SC      = -2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             aln_valid,
    input  logic [3*L+5:0]   r_aligned,
    input  logic [3*L+5:0]   q_aligned,
    output logic             cigar_valid,
    input  logic             cigar_ready,
    output logic [1:0]       cigar_op,
    output logic [7:0]       cigar_len,
    output logic [9:0]       score,
    output logic             busy,
    output logic             done,
    output logic             malformed
);
    localparam int unsigned N    = L + 2;
    localparam int unsigned W    = 3 * N;
    localparam int unsigned ColW = $clog2(N);

    localparam logic [1:0] OpM = 2'b00;
    localparam logic [1:0] OpX = 2'b01;
    localparam logic [1:0] OpI = 2'b10;
    localparam logic [1:0] OpD = 2'b11;

    localparam logic [9:0] ScMatch    = 10'(MATCH_SC);
    localparam logic [9:0] ScMismatch = 10'(MISMATCH_SC);
    localparam logic [9:0] ScGap      = 10'(GAP_SC);

    typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      r_sh_q, r_sh_d, q_sh_q, q_sh_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [1:0]        run_op_q, run_op_d;
    logic [7:0]        run_len_q, run_len_d;
    logic [9:0]        score_q, score_d;
    logic              malformed_q, malformed_d;
    logic              slot_valid_q, slot_valid_d;
    logic [1:0]        slot_op_q, slot_op_d;
    logic [7:0]        slot_len_q, slot_len_d;

    logic [2:0] r_sym, q_sym;
    logic       r_base, q_base, r_gap, q_gap, r_pad, q_pad;
    logic       col_skip, col_bad, extend, stall, slot_free;
    logic [1:0] col_op;
    logic [9:0] col_sc;

    // The vectors are shifted left so the column being processed is always at the top.
    always_comb begin
        r_sym  = r_sh_q[W-1 -: 3];
        q_sym  = q_sh_q[W-1 -: 3];
        r_base = (r_sym != 3'd0) && (r_sym <= 3'd4);
        q_base = (q_sym != 3'd0) && (q_sym <= 3'd4);
        r_gap  = (r_sym == 3'b111);
        q_gap  = (q_sym == 3'b111);
        r_pad  = !r_base && !r_gap;
        q_pad  = !q_base && !q_gap;

        col_skip = 1'b0;
        col_bad  = 1'b0;
        col_op   = OpM;
        if (r_pad || q_pad) begin
            col_skip = 1'b1;
            col_bad  = !(r_pad && q_pad);
        end else if (r_gap && q_gap) begin
            col_skip = 1'b1;
        end else if (r_gap) begin
            col_op = OpI;
        end else if (q_gap) begin
            col_op = OpD;
        end else if (r_sym == q_sym) begin
            col_op = OpM;
        end else begin
            col_op = OpX;
        end

        unique case (col_op)
            OpM:     col_sc = ScMatch;
            OpX:     col_sc = ScMismatch;
            default: col_sc = ScGap;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        r_sh_d       = r_sh_q;
        q_sh_d       = q_sh_q;
        col_d        = col_q;
        run_op_d     = run_op_q;
        run_len_d    = run_len_q;
        score_d      = score_q;
        malformed_d  = malformed_q;
        slot_valid_d = slot_valid_q;
        slot_op_d    = slot_op_q;
        slot_len_d   = slot_len_q;

        // The slot may be reloaded in the same cycle its current entry is accepted.
        slot_free = !slot_valid_q || cigar_ready;
        extend    = !col_skip && (col_op == run_op_q) && (run_len_q != 8'hff);
        stall     = !col_skip && !extend && (run_len_q != 8'd0) && !slot_free;

        if (slot_valid_q && cigar_ready) begin
            slot_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (aln_valid) begin
                    r_sh_d      = r_aligned;
                    q_sh_d      = q_aligned;
                    score_d     = '0;
                    malformed_d = 1'b0;
                    run_len_d   = '0;
                    col_d       = ColW'(N - 1);
                    state_d     = StScan;
                end
            end
            StScan: begin
                if (!stall) begin
                    r_sh_d = r_sh_q << 3;
                    q_sh_d = q_sh_q << 3;
                    col_d  = col_q - ColW'(1);
                    if (col_bad) begin
                        malformed_d = 1'b1;
                    end
                    if (!col_skip) begin
                        score_d = score_q + col_sc;
                        if (extend) begin
                            run_len_d = run_len_q + 8'd1;
                        end else begin
                            if (run_len_q != 8'd0) begin
                                slot_valid_d = 1'b1;
                                slot_op_d    = run_op_q;
                                slot_len_d   = run_len_q;
                            end
                            run_op_d  = col_op;
                            run_len_d = 8'd1;
                        end
                    end
                    if (col_q == '0) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (run_len_q != 8'd0) begin
                    if (slot_free) begin
                        slot_valid_d = 1'b1;
                        slot_op_d    = run_op_q;
                        slot_len_d   = run_len_q;
                        run_len_d    = '0;
                    end
                end else if (!slot_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            r_sh_q       <= '0;
            q_sh_q       <= '0;
            col_q        <= '0;
            run_op_q     <= OpM;
            run_len_q    <= '0;
            score_q      <= '0;
            malformed_q  <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_op_q    <= OpM;
            slot_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            r_sh_q       <= r_sh_d;
            q_sh_q       <= q_sh_d;
            col_q        <= col_d;
            run_op_q     <= run_op_d;
            run_len_q    <= run_len_d;
            score_q      <= score_d;
            malformed_q  <= malformed_d;
            slot_valid_q <= slot_valid_d;
            slot_op_q    <= slot_op_d;
            slot_len_q   <= slot_len_d;
        end
    end

    always_comb begin
        cigar_valid = slot_valid_q;
        cigar_op    = slot_op_q;
        cigar_len   = slot_len_q;
        score       = score_q;
        malformed   = malformed_q;
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
    end

endmodule

// File: tb/tb_alignment_cigar_encoder.sv
// Bench for alignment_cigar_encoder: directed vector table, corner sequences
// (stall, re-pulse, mid-job reset) and random jobs checked against a column-list model.
module tb_alignment_cigar_encoder;
    localparam int L = 8;
    localparam int N = L + 2;
    localparam int W = 3 * N;

    localparam logic [2:0] SP = 3'd0;
    localparam logic [2:0] SA = 3'd1;
    localparam logic [2:0] SC = 3'd2;
    localparam logic [2:0] SG = 3'd3;
    localparam logic [2:0] ST = 3'd4;
    localparam logic [2:0] SX = 3'd7;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         aln_valid;
    logic [W-1:0] r_aligned, q_aligned;
    logic         cigar_valid, cigar_ready;
    logic [1:0]   cigar_op;
    logic [7:0]   cigar_len;
    logic [9:0]   score;
    logic         busy, done, malformed;

    alignment_cigar_encoder #(.L(L)) dut (
        .clk(clk), .reset_n(reset_n), .aln_valid(aln_valid),
        .r_aligned(r_aligned), .q_aligned(q_aligned),
        .cigar_valid(cigar_valid), .cigar_ready(cigar_ready),
        .cigar_op(cigar_op), .cigar_len(cigar_len), .score(score),
        .busy(busy), .done(done), .malformed(malformed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int m_score;
    logic m_mal;
    bit m_any;
    logic [W-1:0] vr, vq;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] q;
        int           stall;
        int           score;
        logic         mal;
        int           n;
        logic [39:0]  ent;
        int           done_k;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int id, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s job%0d: got %0d expected %0d", name, id, act, exp);
        end
    endtask

    function automatic logic [9:0] e(input logic [1:0] op, input int len);
        return {op, 8'(len)};
    endfunction

    // Forward position i lives at column N-1-i.
    task automatic pair(input int i, input logic [2:0] a, input logic [2:0] b);
        vr[3*(N-1-i) +: 3] = a;
        vq[3*(N-1-i) +: 3] = b;
    endtask

    function automatic int kind(input logic [2:0] s);
        if (s == 3'd7) return 2;
        if (s >= 3'd1 && s <= 3'd4) return 1;
        return 0;
    endfunction

    // Reference: list the ops of non-skipped columns in forward order, then compress.
    function automatic void model(input logic [W-1:0] r, input logic [W-1:0] q);
        int ops[$];
        exp_q.delete();
        m_score = 0;
        m_mal = 1'b0;
        for (int c = N - 1; c >= 0; c--) begin
            logic [2:0] a = r[3*c +: 3];
            logic [2:0] b = q[3*c +: 3];
            int ka = kind(a);
            int kb = kind(b);
            if (ka == 0 || kb == 0) begin
                if (!(ka == 0 && kb == 0)) m_mal = 1'b1;
            end else if (ka == 2 && kb == 2) begin
            end else if (ka == 2) begin
                ops.push_back(2); m_score += -2;
            end else if (kb == 2) begin
                ops.push_back(3); m_score += -2;
            end else if (a == b) begin
                ops.push_back(0); m_score += 2;
            end else begin
                ops.push_back(1); m_score += -1;
            end
        end
        m_any = (ops.size() != 0);
        for (int i = 0; i < ops.size(); i++) begin
            if (exp_q.size() == 0 || int'(exp_q[$][9:8]) != ops[i] || exp_q[$][7:0] == 8'hff)
                exp_q.push_back({2'(ops[i]), 8'd1});
            else
                exp_q[$] = exp_q[$] + 10'd1;
        end
    endfunction

    function automatic logic [2:0] rnd_sym();
        int v = int'($urandom_range(0, 15));
        if (v < 10) return 3'(1 + v % 4);
        if (v < 13) return SX;
        case (v)
            13:      return SP;
            14:      return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    // mode 0: always ready; 1: ready low for stall_len cycles once the first entry shows;
    // 2: random ready.
    task automatic run_job(input int id, input logic [W-1:0] r, input logic [W-1:0] q,
                           input int mode, input int stall_len, input int repulse_k,
                           input logic [W-1:0] alt_r, input logic [W-1:0] alt_q,
                           output int done_k);
        int held = 0;
        bit seen = 0;
        bit prev_nack = 0;
        logic [9:0] prev_ent = '0;
        got_q.delete();
        r_aligned = r;
        q_aligned = q;
        aln_valid = 1'b1;
        @(posedge clk); #1;
        aln_valid = 1'b0;
        r_aligned = alt_r;
        q_aligned = alt_q;
        done_k = -1;
        for (int k = 1; k <= 300; k++) begin
            if (mode == 0) begin
                cigar_ready = 1'b1;
            end else if (mode == 1) begin
                if (cigar_valid) seen = 1;
                if (seen && held < stall_len) begin
                    cigar_ready = 1'b0;
                    held++;
                end else begin
                    cigar_ready = 1'b1;
                end
            end else begin
                cigar_ready = 1'($urandom_range(0, 1));
            end
            if (prev_nack) begin
                chk("held_valid", id, int'(cigar_valid), 1);
                chk("held_entry", id, int'({cigar_op, cigar_len}), int'(prev_ent));
            end
            prev_nack = cigar_valid && !cigar_ready;
            prev_ent = {cigar_op, cigar_len};
            if (cigar_valid && cigar_ready) got_q.push_back({cigar_op, cigar_len});
            aln_valid = (k == repulse_k);
            @(posedge clk); #1;
            aln_valid = 1'b0;
            if (done) begin
                done_k = k;
                break;
            end
        end
        if (done_k < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout job%0d: got no done expected done within 300 cycles", id);
        end else begin
            cigar_ready = 1'b1;
            @(posedge clk); #1;
            chk("done_one_cycle", id, int'(done), 0);
            chk("busy_after_done", id, int'(busy), 0);
        end
    endtask

    task automatic compare_job(input int id, input int exp_score, input logic exp_mal,
                               input int exp_done, input int done_k);
        chk("n_entries", id, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("entry", id, int'(got_q[i]), int'(exp_q[i]));
        chk("score", id, int'($signed(score)), exp_score);
        chk("malformed", id, int'(malformed), int'(exp_mal));
        if (exp_done >= 0) chk("done_cycle", id, done_k, exp_done);
    endtask

    initial begin
        int dk;
        int dcount;
        int mode;
        logic [2:0] a;
        logic [2:0] b;

        // Directed table.
        vr = '0; vq = '0;
        pair(2, SA, SA); pair(3, SC, SC); pair(4, SG, SG); pair(5, ST, ST);
        pair(6, SA, SA); pair(7, SC, SC); pair(8, SG, SG); pair(9, ST, ST);
        tbl[0] = '{vr, vq, 0, 16, 1'b0, 1, {30'd0, e(2'b00, 8)}, N + 3};

        vr = '0; vq = '0;
        pair(0, SA, SA); pair(1, SC, SC); pair(2, SG, ST); pair(3, ST, ST); pair(4, SA, SA);
        tbl[1] = '{vr, vq, 0, 7, 1'b0, 3, {10'd0, e(2'b00, 2), e(2'b01, 1), e(2'b00, 2)}, N + 3};
        tbl[3] = '{vr, vq, 5, 7, 1'b0, 3, {10'd0, e(2'b00, 2), e(2'b01, 1), e(2'b00, 2)}, N + 8};

        vr = '0; vq = '0;
        pair(0, SA, SA); pair(1, SG, SG); pair(2, SX, SC); pair(3, SX, ST);
        pair(4, SA, SX); pair(5, SC, SC);
        tbl[2] = '{vr, vq, 0, 0, 1'b0, 4,
                   {e(2'b00, 1), e(2'b11, 1), e(2'b10, 2), e(2'b00, 2)}, N + 3};

        vr = '0; vq = '0;
        pair(0, SA, SP); pair(1, SA, SA); pair(2, SC, SC);
        tbl[4] = '{vr, vq, 0, 4, 1'b1, 1, {30'd0, e(2'b00, 2)}, N + 3};

        vr = '0; vq = '0;
        pair(0, SX, SX);
        tbl[5] = '{vr, vq, 0, 0, 1'b0, 0, 40'd0, N + 1};

        vr = '0; vq = '0;
        pair(0, 3'd5, 3'd6); pair(1, SX, SX); pair(2, ST, ST);
        tbl[6] = '{vr, vq, 0, 2, 1'b0, 1, {30'd0, e(2'b00, 1)}, N + 3};

        reset_n = 1'b0;
        aln_valid = 1'b0;
        cigar_ready = 1'b1;
        r_aligned = '0;
        q_aligned = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 0, int'(cigar_valid), 0);
        chk("reset_busy", 0, int'(busy), 0);
        chk("reset_done", 0, int'(done), 0);
        chk("reset_score", 0, int'(score), 0);
        chk("reset_malformed", 0, int'(malformed), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_job(i + 1, tbl[i].r, tbl[i].q, (tbl[i].stall > 0) ? 1 : 0, tbl[i].stall, 0,
                    '0, '0, dk);
            exp_q.delete();
            for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].ent[10*j +: 10]);
            compare_job(i + 1, tbl[i].score, tbl[i].mal, tbl[i].done_k, dk);
        end

        // Re-pulse of aln_valid mid-scan is ignored; the following job starts from score 0.
        run_job(20, tbl[1].r, tbl[1].q, 0, 0, 3, tbl[0].r, tbl[0].q, dk);
        model(tbl[1].r, tbl[1].q);
        compare_job(20, 7, 1'b0, N + 3, dk);
        run_job(21, tbl[0].r, tbl[0].q, 0, 0, 0, '0, '0, dk);
        model(tbl[0].r, tbl[0].q);
        compare_job(21, 16, 1'b0, N + 3, dk);

        // Asynchronous reset in the middle of a job.
        r_aligned = tbl[4].r;
        q_aligned = tbl[4].q;
        aln_valid = 1'b1;
        @(posedge clk); #1;
        aln_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_busy", 30, int'(busy), 1);
        chk("pre_reset_malformed", 30, int'(malformed), 1);
        chk("pre_reset_score", 30, int'($signed(score)), 4);
        reset_n = 1'b0;
        #1;
        chk("abort_valid", 30, int'(cigar_valid), 0);
        chk("abort_busy", 30, int'(busy), 0);
        chk("abort_done", 30, int'(done), 0);
        chk("abort_score", 30, int'(score), 0);
        chk("abort_malformed", 30, int'(malformed), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("aborted_job_done", 30, dcount, 0);
        run_job(31, tbl[1].r, tbl[1].q, 0, 0, 0, '0, '0, dk);
        model(tbl[1].r, tbl[1].q);
        compare_job(31, 7, 1'b0, N + 3, dk);

        // Random jobs against the reference model.
        for (int j = 0; j < 40; j++) begin
            vr = '0;
            vq = '0;
            for (int c = 0; c < N; c++) begin
                a = rnd_sym();
                b = ($urandom_range(0, 9) < 6) ? a : rnd_sym();
                pair(c, a, b);
            end
            mode = (j % 2 == 0) ? 0 : 2;
            run_job(100 + j, vr, vq, mode, 0, 0, '0, '0, dk);
            model(vr, vq);
            compare_job(100 + j, m_score, m_mal, (mode == 0) ? (m_any ? N + 3 : N + 1) : -1,
                        dk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
